// File: rtl/mipi_csi_tx_packet_scheduler.sv
// ----------------------------------------------------------------------------
// mipi_csi_tx_packet_scheduler
//
// Transmit-side CSI-2 packet scheduler. It watches frame_valid/line_valid from
// the pixel source and turns their edges into sync events. Each event is queued
// in a small FIFO so that header back-pressure never loses an edge. The events
// are then issued as packet headers over a valid/ready handshake, in this order:
//   FS -> LS -> long-packet header (LPH) -> LE -> FE
// The block also owns frame and line numbering.
//
// Ports
//   clk_i, reset_n_i        clock, asynchronous active-low reset
//   enable_i                1 = detect new edges; 0 = ignore them, drain FIFO
//   frame_valid_i           frame valid from the pixel source
//   line_valid_i            line valid from the pixel source
//   vc_id_i, data_type_i,
//   word_count_i            frame parameters, latched when FS is processed
//   line_sync_en_i          1 = emit LS/LE short packets around each line
//   clear_err_i             pulse: clear the sticky error flags
//   header_valid_o          header fields valid (held until header_ready_i)
//   header_ready_i          downstream accepts the header
//   header_vc_id_o, header_data_type_o, header_data_o, header_long_o
//                           header fields
//   frame_num_o             frame number of the current/last frame
//   err_fifo_overflow_o     sticky: an event was lost because the FIFO was full
//   err_protocol_o          sticky: line edge seen while frame_valid was low
// ----------------------------------------------------------------------------
module mipi_csi_tx_packet_scheduler #(
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter logic [15:0] FRAME_NUM_MAX = 16'hFFFF
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        enable_i,
    input  logic        frame_valid_i,
    input  logic        line_valid_i,
    input  logic [1:0]  vc_id_i,
    input  logic [5:0]  data_type_i,
    input  logic [15:0] word_count_i,
    input  logic        line_sync_en_i,
    input  logic        clear_err_i,
    output logic        header_valid_o,
    input  logic        header_ready_i,
    output logic [1:0]  header_vc_id_o,
    output logic [5:0]  header_data_type_o,
    output logic [15:0] header_data_o,
    output logic        header_long_o,
    output logic [15:0] frame_num_o,
    output logic        err_fifo_overflow_o,
    output logic        err_protocol_o
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    // The state encoding follows header order, so "next present header after
    // state X" is just "the lowest present header ranked above X".
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_FS   = 3'd1;
    localparam logic [2:0] ST_LS   = 3'd2;
    localparam logic [2:0] ST_LPH  = 3'd3;
    localparam logic [2:0] ST_LE   = 3'd4;
    localparam logic [2:0] ST_FE   = 3'd5;

    localparam logic [5:0] DT_FSC = 6'h00;
    localparam logic [5:0] DT_FEC = 6'h01;
    localparam logic [5:0] DT_LSC = 6'h02;
    localparam logic [5:0] DT_LEC = 6'h03;

    // Event entry layout: {FE, LE, LS, FS}
    function automatic logic [2:0] next_hdr(input logic [2:0] cur_st,
                                            input logic [3:0] ev,
                                            input logic       sync_en);
        next_hdr = ST_IDLE;
        if (cur_st < ST_FE  && ev[3])            next_hdr = ST_FE;
        if (cur_st < ST_LE  && ev[2] && sync_en) next_hdr = ST_LE;
        if (cur_st < ST_LPH && ev[1])            next_hdr = ST_LPH;
        if (cur_st < ST_LS  && ev[1] && sync_en) next_hdr = ST_LS;
        if (cur_st < ST_FS  && ev[0])            next_hdr = ST_FS;
    endfunction

    // ------------------------------------------------------------------
    // Edge detection
    // ------------------------------------------------------------------
    logic       fv_r_q, lv_r_q;
    logic       fs_flag, fe_flag, ls_flag, le_flag;
    logic       proto_err_set;
    logic [3:0] new_flags;
    logic       push_req;

    assign fs_flag = frame_valid_i & ~fv_r_q;
    assign fe_flag = ~frame_valid_i & fv_r_q;
    assign ls_flag = line_valid_i & ~lv_r_q & frame_valid_i;
    // A falling line edge counts only if the frame is (or just was) open.
    // This keeps LE+FE on the same cycle as one legal entry.
    assign le_flag = ~line_valid_i & lv_r_q & (frame_valid_i | fv_r_q);
    assign proto_err_set = enable_i & (line_valid_i ^ lv_r_q)
                         & ~frame_valid_i & ~fv_r_q;

    assign new_flags = {fe_flag, le_flag, ls_flag, fs_flag};
    assign push_req  = enable_i & (|new_flags);

    // ------------------------------------------------------------------
    // Event FIFO
    // ------------------------------------------------------------------
    logic [3:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_nx;
    logic [CW-1:0] count_q;
    logic          fifo_full, fifo_empty;
    logic          pop, push_ok, overflow_set;
    logic [3:0]    head_entry, second_entry;

    assign fifo_full    = (count_q == CW'(FIFO_DEPTH));
    assign fifo_empty   = (count_q == '0);
    assign rd_ptr_nx    = rd_ptr_q + 1'b1;
    assign head_entry   = fifo_mem[rd_ptr_q];
    assign second_entry = fifo_mem[rd_ptr_nx];
    // A pop in the same cycle frees the slot, so a push into a full FIFO is legal then.
    assign push_ok      = push_req & (~fifo_full | pop);
    assign overflow_set = push_req & fifo_full & ~pop;

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_q] <= new_flags;
        end
    end

    // ------------------------------------------------------------------
    // Header FSM
    // ------------------------------------------------------------------
    logic [2:0]  state_q, state_d;
    logic [3:0]  cur_q, cur_d;
    logic        load;
    logic [3:0]  load_entry;
    logic        line_inc;
    logic [2:0]  nxt_st;
    logic [15:0] frame_num_q, line_num_q;
    logic [1:0]  vc_q;
    logic [5:0]  dt_q;
    logic [15:0] wc_q;
    logic        err_ovf_q, err_proto_q;

    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        pop        = 1'b0;
        load       = 1'b0;
        load_entry = head_entry;
        line_inc   = 1'b0;
        nxt_st     = ST_IDLE;
        if (state_q == ST_IDLE) begin
            if (!fifo_empty) begin
                if (next_hdr(ST_IDLE, head_entry, line_sync_en_i) == ST_IDLE) begin
                    // An LE-only entry with line sync disabled emits nothing.
                    // It still advances the line number.
                    pop      = 1'b1;
                    line_inc = head_entry[2];
                end else begin
                    load = 1'b1;
                end
            end
        end else if (header_ready_i) begin
            nxt_st = next_hdr(state_q, cur_q, line_sync_en_i);
            if (nxt_st != ST_IDLE) begin
                state_d = nxt_st;
            end else begin
                // Last header of this entry: retire it. If another entry is
                // already queued, start on it directly with no idle cycle.
                pop      = 1'b1;
                line_inc = cur_q[2];
                state_d  = ST_IDLE;
                if (count_q > CW'(1)) begin
                    load_entry = second_entry;
                    load       = next_hdr(ST_IDLE, second_entry, line_sync_en_i) != ST_IDLE;
                end
            end
        end
        if (load) begin
            state_d = next_hdr(ST_IDLE, load_entry, line_sync_en_i);
            cur_d   = load_entry;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            fv_r_q      <= 1'b0;
            lv_r_q      <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= ST_IDLE;
            cur_q       <= '0;
            frame_num_q <= '0;
            line_num_q  <= '0;
            vc_q        <= '0;
            dt_q        <= '0;
            wc_q        <= '0;
            err_ovf_q   <= 1'b0;
            err_proto_q <= 1'b0;
        end else begin
            fv_r_q  <= frame_valid_i;
            lv_r_q  <= line_valid_i;
            state_q <= state_d;
            cur_q   <= cur_d;

            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_q <= rd_ptr_nx;
            if (push_ok && !pop)      count_q <= count_q + 1'b1;
            else if (!push_ok && pop) count_q <= count_q - 1'b1;

            // FS is processed when its entry is loaded. The FS header then
            // carries the new frame number, and every later header of the
            // frame uses the latched parameters.
            if (load && load_entry[0]) begin
                frame_num_q <= (frame_num_q == FRAME_NUM_MAX) ? 16'd1 : frame_num_q + 16'd1;
                line_num_q  <= 16'd1;
                vc_q        <= vc_id_i;
                dt_q        <= data_type_i;
                wc_q        <= word_count_i;
            end else if (line_inc) begin
                line_num_q <= (line_num_q == 16'hFFFF) ? 16'd1 : line_num_q + 16'd1;
            end

            // Clear first, set after: a new error in the clear cycle survives.
            if (clear_err_i) begin
                err_ovf_q   <= 1'b0;
                err_proto_q <= 1'b0;
            end
            if (overflow_set)  err_ovf_q   <= 1'b1;
            if (proto_err_set) err_proto_q <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Header outputs (decoded from state, so reset drops valid at once)
    // ------------------------------------------------------------------
    always_comb begin
        header_valid_o     = (state_q != ST_IDLE);
        header_vc_id_o     = '0;
        header_data_type_o = '0;
        header_data_o      = '0;
        header_long_o      = 1'b0;
        case (state_q)
            ST_FS: begin
                header_vc_id_o     = vc_q;
                header_data_type_o = DT_FSC;
                header_data_o      = frame_num_q;
            end
            ST_LS: begin
                header_vc_id_o     = vc_q;
                header_data_type_o = DT_LSC;
                header_data_o      = line_num_q;
            end
            ST_LPH: begin
                header_vc_id_o     = vc_q;
                header_data_type_o = dt_q;
                header_data_o      = wc_q;
                header_long_o      = 1'b1;
            end
            ST_LE: begin
                header_vc_id_o     = vc_q;
                header_data_type_o = DT_LEC;
                header_data_o      = line_num_q;
            end
            ST_FE: begin
                header_vc_id_o     = vc_q;
                header_data_type_o = DT_FEC;
                header_data_o      = frame_num_q;
            end
            default: ;
        endcase
    end

    assign frame_num_o         = frame_num_q;
    assign err_fifo_overflow_o = err_ovf_q;
    assign err_protocol_o      = err_proto_q;

endmodule

// File: tb/tb_mipi_csi_tx_packet_scheduler.sv
// ----------------------------------------------------------------------------
// Testbench for mipi_csi_tx_packet_scheduler.
// Expected headers are pushed to a queue as the stimulus is driven. A monitor
// pops and compares one entry for every accepted header. FRAME_NUM_MAX is
// reduced to 3 so that frame-number wrap can be reached in a short run.
// ----------------------------------------------------------------------------
module tb_mipi_csi_tx_packet_scheduler;

    localparam logic [15:0] FNUM_MAX = 16'd3;

    typedef struct packed {
        logic [1:0]  vc;
        logic [5:0]  dt;
        logic [15:0] data;
        logic        lng;
    } hdr_t;

    logic        clk_i = 1'b0;
    logic        reset_n_i;
    logic        enable_i;
    logic        frame_valid_i;
    logic        line_valid_i;
    logic [1:0]  vc_id_i;
    logic [5:0]  data_type_i;
    logic [15:0] word_count_i;
    logic        line_sync_en_i;
    logic        clear_err_i;
    logic        header_valid_o;
    logic        header_ready_i;
    logic [1:0]  header_vc_id_o;
    logic [5:0]  header_data_type_o;
    logic [15:0] header_data_o;
    logic        header_long_o;
    logic [15:0] frame_num_o;
    logic        err_fifo_overflow_o;
    logic        err_protocol_o;

    int   checks = 0;
    int   errors = 0;
    hdr_t exp_q[$];
    hdr_t mon_got, mon_exp;

    mipi_csi_tx_packet_scheduler #(
        .FIFO_DEPTH   (4),
        .FRAME_NUM_MAX(FNUM_MAX)
    ) dut (
        .clk_i              (clk_i),
        .reset_n_i          (reset_n_i),
        .enable_i           (enable_i),
        .frame_valid_i      (frame_valid_i),
        .line_valid_i       (line_valid_i),
        .vc_id_i            (vc_id_i),
        .data_type_i        (data_type_i),
        .word_count_i       (word_count_i),
        .line_sync_en_i     (line_sync_en_i),
        .clear_err_i        (clear_err_i),
        .header_valid_o     (header_valid_o),
        .header_ready_i     (header_ready_i),
        .header_vc_id_o     (header_vc_id_o),
        .header_data_type_o (header_data_type_o),
        .header_data_o      (header_data_o),
        .header_long_o      (header_long_o),
        .frame_num_o        (frame_num_o),
        .err_fifo_overflow_o(err_fifo_overflow_o),
        .err_protocol_o     (err_protocol_o)
    );

    always #5 clk_i = ~clk_i;

    // Scoreboard monitor: a header is accepted at the posedge that follows a
    // negedge where valid & ready are both high.
    always @(negedge clk_i) begin
        if (reset_n_i && header_valid_o && header_ready_i) begin
            mon_got = '{vc: header_vc_id_o, dt: header_data_type_o,
                        data: header_data_o, lng: header_long_o};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_header: got vc=%0d dt=%h data=%h long=%b, expected no header",
                         mon_got.vc, mon_got.dt, mon_got.data, mon_got.lng);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp) begin
                    errors++;
                    $display("FAIL header: got vc=%0d dt=%h data=%h long=%b, expected vc=%0d dt=%h data=%h long=%b",
                             mon_got.vc, mon_got.dt, mon_got.data, mon_got.lng,
                             mon_exp.vc, mon_exp.dt, mon_exp.data, mon_exp.lng);
                end else begin
                    $display("hdr  t=%0t vc=%0d dt=%h data=%h long=%b",
                             $time, mon_got.vc, mon_got.dt, mon_got.data, mon_got.lng);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push_exp(input logic [5:0] dt, input logic [15:0] data, input logic lng);
        hdr_t h;
        h.vc   = vc_id_i;
        h.dt   = dt;
        h.data = data;
        h.lng  = lng;
        exp_q.push_back(h);
    endtask

    // Wait (bounded) for every expected header to be accepted.
    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        repeat (3) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d headers still outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        reset_n_i      = 1'b0;
        enable_i       = 1'b1;
        frame_valid_i  = 1'b0;
        line_valid_i   = 1'b0;
        vc_id_i        = 2'd1;
        data_type_i    = 6'h2A;
        word_count_i   = 16'h0280;
        line_sync_en_i = 1'b1;
        clear_err_i    = 1'b0;
        header_ready_i = 1'b1;
        repeat (3) tick();
        checks++;
        if ({header_valid_o, header_vc_id_o, header_data_type_o, header_data_o, header_long_o} !== 26'd0) begin
            errors++;
            $display("FAIL reset_header: got %h, required 0",
                     {header_valid_o, header_vc_id_o, header_data_type_o, header_data_o, header_long_o});
        end
        checks++;
        if ({frame_num_o, err_fifo_overflow_o, err_protocol_o} !== 18'd0) begin
            errors++;
            $display("FAIL reset_status: got frame=%h ovf=%b proto=%b, required 0 0 0",
                     frame_num_o, err_fifo_overflow_o, err_protocol_o);
        end
        reset_n_i = 1'b1;
        repeat (3) tick();
        checks++;
        if (header_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_valid: got %b, required 0", header_valid_o);
        end
    endtask

    // One frame, two lines, line sync on, ready held high.
    task automatic test_frame();
        tick(); frame_valid_i = 1'b1; push_exp(6'h00, 16'd1, 1'b0);
        repeat (3) tick(); line_valid_i = 1'b1;
        push_exp(6'h02, 16'd1, 1'b0); push_exp(6'h2A, 16'h0280, 1'b1);
        repeat (4) tick(); line_valid_i = 1'b0; push_exp(6'h03, 16'd1, 1'b0);
        repeat (4) tick(); line_valid_i = 1'b1;
        push_exp(6'h02, 16'd2, 1'b0); push_exp(6'h2A, 16'h0280, 1'b1);
        repeat (4) tick(); line_valid_i = 1'b0; push_exp(6'h03, 16'd2, 1'b0);
        repeat (4) tick(); frame_valid_i = 1'b0; push_exp(6'h01, 16'd1, 1'b0);
        drain("frame");
        checks++;
        if (frame_num_o !== 16'd1) begin
            errors++;
            $display("FAIL frame_num_after_frame: got %0d, required 1", frame_num_o);
        end
    endtask

    // fv and lv rise together: one entry, FS at N+1, LS at N+2, LPH at N+3.
    task automatic test_simultaneous();
        vc_id_i = 2'd2; data_type_i = 6'h1E; word_count_i = 16'h0010;
        tick();
        frame_valid_i = 1'b1; line_valid_i = 1'b1;
        push_exp(6'h00, 16'd2, 1'b0); push_exp(6'h02, 16'd1, 1'b0); push_exp(6'h1E, 16'h0010, 1'b1);
        tick();   // edge sampled and pushed here (N)
        checks++;
        if (header_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL simul_latency_N: valid got %b, required 0", header_valid_o);
        end
        tick();   // N+1
        checks++;
        if ({header_valid_o, header_data_type_o, header_data_o} !== {1'b1, 6'h00, 16'd2}) begin
            errors++;
            $display("FAIL simul_fs_N1: got v=%b dt=%h d=%h, required v=1 dt=00 d=0002",
                     header_valid_o, header_data_type_o, header_data_o);
        end
        tick();   // N+2
        checks++;
        if ({header_valid_o, header_data_type_o, header_data_o} !== {1'b1, 6'h02, 16'd1}) begin
            errors++;
            $display("FAIL simul_ls_N2: got v=%b dt=%h d=%h, required v=1 dt=02 d=0001",
                     header_valid_o, header_data_type_o, header_data_o);
        end
        tick();   // N+3
        checks++;
        if ({header_valid_o, header_data_type_o, header_long_o} !== {1'b1, 6'h1E, 1'b1}) begin
            errors++;
            $display("FAIL simul_lph_N3: got v=%b dt=%h long=%b, required v=1 dt=1e long=1",
                     header_valid_o, header_data_type_o, header_long_o);
        end
        repeat (4) tick();
        line_valid_i = 1'b0; frame_valid_i = 1'b0;
        push_exp(6'h03, 16'd1, 1'b0); push_exp(6'h01, 16'd2, 1'b0);
        drain("simul");
        vc_id_i = 2'd1; data_type_i = 6'h2A; word_count_i = 16'h0280;
    endtask

    // Back-pressure over five line edges with a 4-entry FIFO: the fifth is lost.
    task automatic test_overflow();
        tick(); frame_valid_i = 1'b1; push_exp(6'h00, 16'd3, 1'b0);
        repeat (4) tick();
        header_ready_i = 1'b0;
        tick(); line_valid_i = 1'b1;
        push_exp(6'h02, 16'd1, 1'b0); push_exp(6'h2A, 16'h0280, 1'b1);
        repeat (4) tick(); line_valid_i = 1'b0; push_exp(6'h03, 16'd1, 1'b0);
        repeat (4) tick(); line_valid_i = 1'b1;
        push_exp(6'h02, 16'd2, 1'b0); push_exp(6'h2A, 16'h0280, 1'b1);
        repeat (4) tick(); line_valid_i = 1'b0; push_exp(6'h03, 16'd2, 1'b0);
        repeat (4) tick(); line_valid_i = 1'b1;   // dropped: FIFO full
        repeat (2) tick();
        checks++;
        if (err_fifo_overflow_o !== 1'b1) begin
            errors++;
            $display("FAIL overflow_flag: got %b, required 1", err_fifo_overflow_o);
        end
        checks++;
        if ({header_valid_o, header_data_type_o, header_data_o} !== {1'b1, 6'h02, 16'd1}) begin
            errors++;
            $display("FAIL overflow_stall_hold: got v=%b dt=%h d=%h, required v=1 dt=02 d=0001",
                     header_valid_o, header_data_type_o, header_data_o);
        end
        repeat (2) tick();
        header_ready_i = 1'b1;
        repeat (10) tick(); line_valid_i = 1'b0; push_exp(6'h03, 16'd3, 1'b0);
        repeat (4) tick(); frame_valid_i = 1'b0; push_exp(6'h01, 16'd3, 1'b0);
        drain("overflow");
    endtask

    // Frame number sits at FRAME_NUM_MAX; the next FS wraps to 1.
    task automatic test_frame_wrap();
        tick(); frame_valid_i = 1'b1; push_exp(6'h00, 16'd1, 1'b0);
        repeat (4) tick();
        checks++;
        if (frame_num_o !== 16'd1) begin
            errors++;
            $display("FAIL frame_wrap: got %0d, required 1", frame_num_o);
        end
        frame_valid_i = 1'b0; push_exp(6'h01, 16'd1, 1'b0);
        drain("wrap");
    endtask

    // Disable mid-frame: queued entries drain, new edges are ignored.
    task automatic test_enable();
        tick(); frame_valid_i = 1'b1; push_exp(6'h00, 16'd2, 1'b0);
        repeat (4) tick();
        header_ready_i = 1'b0;
        line_valid_i = 1'b1;
        push_exp(6'h02, 16'd1, 1'b0); push_exp(6'h2A, 16'h0280, 1'b1);
        tick(); enable_i = 1'b0;
        repeat (2) tick(); line_valid_i = 1'b0;
        repeat (2) tick(); frame_valid_i = 1'b0;
        repeat (2) tick(); header_ready_i = 1'b1;
        drain("enable");
        enable_i = 1'b1;
        repeat (4) tick();
        checks++;
        if (header_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL enable_no_spurious: valid got %b, required 0", header_valid_o);
        end
    endtask

    // Line pulses with frame_valid low give no headers and set the protocol error.
    task automatic test_protocol();
        checks++;
        if (err_fifo_overflow_o !== 1'b1) begin
            errors++;
            $display("FAIL overflow_sticky: got %b, required 1", err_fifo_overflow_o);
        end
        tick(); line_valid_i = 1'b1;
        repeat (2) tick(); line_valid_i = 1'b0;
        repeat (3) tick();
        checks++;
        if ({err_protocol_o, header_valid_o} !== 2'b10) begin
            errors++;
            $display("FAIL protocol_err: got err=%b valid=%b, required err=1 valid=0",
                     err_protocol_o, header_valid_o);
        end
        clear_err_i = 1'b1;
        tick(); clear_err_i = 1'b0;
        checks++;
        if ({err_protocol_o, err_fifo_overflow_o} !== 2'b00) begin
            errors++;
            $display("FAIL clear_err: got proto=%b ovf=%b, required 0 0",
                     err_protocol_o, err_fifo_overflow_o);
        end
        drain("protocol");
    endtask

    // Asynchronous reset during a pending header, then a frame whose first line
    // runs without line sync (LE still advances the line number).
    task automatic test_reset_mid();
        header_ready_i = 1'b0;
        tick(); frame_valid_i = 1'b1;
        repeat (3) tick();
        checks++;
        if (header_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_pending: valid got %b, required 1", header_valid_o);
        end
        #2 reset_n_i = 1'b0;
        #1;
        checks++;
        if ({header_valid_o, header_data_type_o, header_data_o, frame_num_o} !== 39'd0) begin
            errors++;
            $display("FAIL async_reset: got v=%b dt=%h d=%h frame=%h, required all 0",
                     header_valid_o, header_data_type_o, header_data_o, frame_num_o);
        end
        frame_valid_i = 1'b0;
        repeat (2) tick();
        reset_n_i = 1'b1; header_ready_i = 1'b1; line_sync_en_i = 1'b0;
        tick(); frame_valid_i = 1'b1; push_exp(6'h00, 16'd1, 1'b0);
        repeat (4) tick(); line_valid_i = 1'b1; push_exp(6'h2A, 16'h0280, 1'b1);
        repeat (4) tick(); line_valid_i = 1'b0;
        repeat (4) tick(); line_sync_en_i = 1'b1;
        tick(); line_valid_i = 1'b1;
        push_exp(6'h02, 16'd2, 1'b0); push_exp(6'h2A, 16'h0280, 1'b1);
        repeat (4) tick(); line_valid_i = 1'b0; push_exp(6'h03, 16'd2, 1'b0);
        repeat (4) tick(); frame_valid_i = 1'b0; push_exp(6'h01, 16'd1, 1'b0);
        drain("reset_mid");
        checks++;
        if (frame_num_o !== 16'd1) begin
            errors++;
            $display("FAIL frame_after_reset: got %0d, required 1", frame_num_o);
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_simultaneous();
        test_overflow();
        test_frame_wrap();
        test_enable();
        test_protocol();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, required completion");
        $fatal(1, "timeout");
    end

endmodule
